// File: rtl/store_packer.sv
// store_packer: truncates store data to byte/half/word, lane-replicates it and queues word-aligned writes.
// Latency: an entry accepted at edge N is presented on out_* after edge N; no input-to-output bypass.
// Backpressure: in_ready drops when the FIFO is full (same-cycle pop does not free a slot); out_* hold while stalled.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready         store request handshake; in_addr, in_data, in_size describe the store
//   out_valid/out_ready       packed write handshake; out_addr (word aligned), out_wdata, out_be
//   misalign, misalign_addr   one-cycle pulse and captured address of a rejected request
//   count                     occupied FIFO entries

// Generic synchronous FIFO with registered storage that clears on reset.
// Latency: a push at edge N is visible at head_dat after edge N when it lands in the head slot.
// Backpressure: pushes while full and pops while empty are ignored.
module store_packer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module store_packer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_wdata,
  output logic [3:0]       out_be,
  output logic             misalign,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] count
);

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Only the word index of the address is stored; the low bits are folded into be.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t  pack;
  wr_t  head;
  logic legal;
  logic accept;
  logic full;
  logic empty;

  assign accept = in_valid && in_ready;

  // Lane replication means the memory can pick up the right bytes purely from be,
  // independent of where in the word the access lands.
  always_comb begin
    pack.waddr = in_addr[31:2];
    pack.wdata = in_data;
    pack.be    = 4'b0000;
    legal      = 1'b0;
    case (in_size)
      SIZE_B: begin
        pack.wdata = {4{in_data[7:0]}};
        pack.be    = 4'b0001 << in_addr[1:0];
        legal      = 1'b1;
      end
      SIZE_H: begin
        pack.wdata = {2{in_data[15:0]}};
        pack.be    = in_addr[1] ? 4'b1100 : 4'b0011;
        legal      = !in_addr[0];
      end
      SIZE_W: begin
        pack.wdata = in_data;
        pack.be    = 4'b1111;
        legal      = (in_addr[1:0] == 2'b00);
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  store_packer_fifo #(
    .W     ($bits(wr_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept && legal),
    .push_dat (pack),
    .pop      (out_valid && out_ready),
    .head_dat (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // in_ready comes from registered occupancy only, so a full FIFO never
  // takes a push even when the head is retiring in the same cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_addr  = {head.waddr, 2'b00};
  assign out_wdata = head.wdata;
  assign out_be    = head.be;

  // Rejected requests still consume their handshake beat; they only leave a trace here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign <= accept && !legal;
      if (accept && !legal) begin
        misalign_addr <= in_addr;
      end
    end
  end

endmodule

// File: tb/tb_store_packer.sv
module tb_store_packer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [1:0]  count;

  int tests = 0;
  int fails = 0;
  logic [67:0] sbq[$];
  bit wrap_done = 0;

  store_packer #(.DEPTH(2), .CNT_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_size       (in_size),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_wdata     (out_wdata),
    .out_be        (out_be),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: retires expected writes in order whenever the DUT hands one over.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      logic [67:0] e;
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h, expected no write", out_addr);
      end else begin
        e = sbq.pop_front();
        chk("mon_addr", out_addr, e[67:36]);
        chk("mon_wdata", out_wdata, e[35:4]);
        chk("mon_be", {28'd0, out_be}, {28'd0, e[3:0]});
      end
    end
  end

  // Called at posedge+1; presents a request, waits for in_ready, returns at posedge+1
  // right after the accepting edge with in_valid still asserted.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit legal, input logic [31:0] ea, input logic [31:0] ew,
                      input logic [3:0] eb);
    int n = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      if (legal) sbq.push_back({ea, ew, eb});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, sbq.size(), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_count"}, {30'd0, count}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_size = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_misalign_addr", misalign_addr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("empty_no_valid", {31'd0, out_valid}, 32'd0);

    // Byte lane
    send(32'h1003, 32'hDEADBEEF, 2'b00, 1, 32'h1000, 32'hEFEFEFEF, 4'b1000);
    idle();
    chk("sb_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sb_count", {30'd0, count}, 32'd1);
    drain("sb_drain");

    // Halfword and word
    send(32'h2002, 32'h12345678, 2'b01, 1, 32'h2000, 32'h56785678, 4'b1100);
    send(32'h2004, 32'h12345678, 2'b10, 1, 32'h2004, 32'h12345678, 4'b1111);
    idle();
    chk("shsw_count", {30'd0, count}, 32'd2);
    drain("shsw_drain");

    // Misaligned / illegal
    send(32'h3001, 32'h0, 2'b01, 0, 32'h0, 32'h0, 4'h0);
    chk("mis1_pulse", {31'd0, misalign}, 32'd1);
    chk("mis1_addr", misalign_addr, 32'h3001);
    chk("mis1_count", {30'd0, count}, 32'd0);
    send(32'h3002, 32'h0, 2'b10, 0, 32'h0, 32'h0, 4'h0);
    chk("mis2_pulse", {31'd0, misalign}, 32'd1);
    chk("mis2_addr", misalign_addr, 32'h3002);
    send(32'h3000, 32'h0, 2'b11, 0, 32'h0, 32'h0, 4'h0);
    chk("mis3_pulse", {31'd0, misalign}, 32'd1);
    chk("mis3_addr", misalign_addr, 32'h3000);
    idle();
    @(posedge clk);
    #1;
    chk("mis_end_pulse", {31'd0, misalign}, 32'd0);
    chk("mis_end_count", {30'd0, count}, 32'd0);
    chk("mis_end_valid", {31'd0, out_valid}, 32'd0);

    // Full / backpressure: A, B fill, C stalls
    send(32'h5000, 32'hAAAA0000, 2'b10, 1, 32'h5000, 32'hAAAA0000, 4'b1111);
    send(32'h5004, 32'hBBBB0000, 2'b10, 1, 32'h5004, 32'hBBBB0000, 4'b1111);
    in_addr = 32'h5008;
    in_data = 32'hCCCC0000;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {30'd0, count}, 32'd2);
    chk("full_head_addr", out_addr, 32'h5000);
    @(posedge clk);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_head_addr", out_addr, 32'h5000);
    chk("stall_head_wdata", out_wdata, 32'hAAAA0000);
    chk("stall_head_be", {28'd0, out_be}, 32'hF);
    sbq.push_back({32'h5008, 32'hCCCC0000, 4'b1111});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pop_full_count", {30'd0, count}, 32'd1);
    chk("pop_full_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    idle();
    chk("c_accept_count", {30'd0, count}, 32'd1);
    out_ready = 1'b0;
    chk("c_head_addr", out_addr, 32'h5008);
    drain("full_drain");

    // Simultaneous push/pop at count=1
    send(32'h6000, 32'h0000D0D0, 2'b01, 1, 32'h6000, 32'hD0D0D0D0, 4'b0011);
    idle();
    chk("pp_pre_count", {30'd0, count}, 32'd1);
    out_ready = 1'b1;
    send(32'h6005, 32'h000000E5, 2'b00, 1, 32'h6004, 32'hE5E5E5E5, 4'b0010);
    idle();
    chk("pp_count", {30'd0, count}, 32'd1);
    drain("pp_drain");

    // Pointer wrap over 10 entries with random out_ready
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [7:0]  b;
          logic [31:0] a;
          b = 8'hA0 + 8'(i);
          a = 32'h7000 + 32'(i);
          send(a, {24'h123456, b}, 2'b00, 1, {a[31:2], 2'b00}, {b, b, b, b},
               4'b0001 << a[1:0]);
        end
        idle();
        wrap_done = 1;
      end
      begin
        while (!wrap_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain("wrap_drain");

    // Reset mid-stream
    send(32'h4000, 32'h11111111, 2'b10, 1, 32'h4000, 32'h11111111, 4'b1111);
    send(32'h4004, 32'h22222222, 2'b10, 1, 32'h4004, 32'h22222222, 4'b1111);
    in_addr = 32'h4008;
    in_data = 32'h33333333;
    chk("mid_count", {30'd0, count}, 32'd2);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_count", {30'd0, count}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_addr", out_addr, 32'd0);
    chk("mid_rst_wdata", out_wdata, 32'd0);
    chk("mid_rst_be", {28'd0, out_be}, 32'd0);
    sbq.delete();
    @(posedge clk);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rel_count", {30'd0, count}, 32'd0);
    chk("mid_rel_valid", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_packer.md
Name: store_packer

Overview:
- Memory-stage store path. Takes store requests (byte, halfword or word) carrying a 32-bit register value and a byte address.
- Truncates the value to the access size and replicates it into the correct little-endian byte lane(s), producing a word-aligned address and byte enables. This is the narrowing counterpart to immediate/load widening.
- Buffers packed writes in a small FIFO with valid/ready handshakes on both sides, decoupling the pipeline from data-memory stalls.
- Flags misaligned or illegal-size stores instead of enqueuing them.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
CNT_W, 2, width of count output; must hold DEPTH (2 for DEPTH=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  store request valid
in_ready  output  1  packer can accept a request
in_addr  input  32  byte address
in_data  input  32  register value to store
in_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
out_valid  output  1  packed write available
out_ready  input  1  data memory accepts write
out_addr  output  32  word address, {in_addr[31:2],2'b00}
out_wdata  output  32  lane-replicated write data
out_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
misalign  output  1  one-cycle pulse: rejected request
misalign_addr  output  32  address of most recent rejected request
count  output  CNT_W  occupied entries

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count cleared; out_valid=0, misalign=0, misalign_addr=0.
  - FIFO storage cleared, so out_addr/out_wdata/out_be read 0.
  - A request in flight is dropped.
  - in_ready=1 from the first cycle after reset release.
- Handshakes:
  - Input accepted on a rising edge with in_valid && in_ready.
  - Output retired on a rising edge with out_valid && out_ready.
  - in_ready = (count != DEPTH). Combinational from registered state only; it does not depend on out_ready. When full, a same-cycle pop does not allow a push.
- Packing of an accepted, legal request:
  - Byte (00): wdata={4{in_data[7:0]}}, be=4'b0001<<in_addr[1:0].
  - Half (01): wdata={2{in_data[15:0]}}, be = in_addr[1] ? 4'b1100 : 4'b0011.
  - Word (10): wdata=in_data, be=4'b1111.
  - Upper bits of in_data beyond the access size are ignored.
- Legality:
  - Illegal when: half with in_addr[0]=1; word with in_addr[1:0]!=0; or in_size=11.
  - An illegal request is handshaken (consumes the in_valid && in_ready beat) but not enqueued.
  - misalign=1 for exactly the following cycle; misalign_addr=in_addr is registered at the same edge. count is unchanged.
  - Back-to-back illegal requests give back-to-back pulses.
- Latency:
  - An entry accepted at edge N drives out_valid=1 with its data after edge N (available to be retired at edge N+1).
  - FIFO order is preserved; there is no bypass from input to output.
- Output stability: while out_valid && !out_ready, out_addr, out_wdata and out_be hold constant.
- Count and pointers:
  - Push only: count+1. Pop only: count-1. Push and pop together (count between 1 and DEPTH-1): count unchanged.
  - Pointers wrap modulo DEPTH.
- Empty: out_valid=0; out_ready is ignored.

Test Plan:
- Reset mid-stream: enqueue 2 words (count=2), assert rst=0 asynchronously between edges -> immediately count=0, out_valid=0, outputs 0; after release in_ready=1.
- Byte lanes: sb of in_data=32'hDEADBEEF at addr 32'h1003 -> out_addr=32'h1000, out_wdata=32'hEFEFEFEF, out_be=4'b1000, out_valid one cycle after acceptance.
- Halfword and word: sh in_data=32'h12345678 at 32'h2002 -> wdata 32'h56785678, be 4'b1100; sw at 32'h2004 -> wdata 32'h12345678, be 4'b1111, out_addr 32'h2004.
- Misalign: sh at 32'h3001 -> misalign pulse one cycle, misalign_addr=32'h3001, count stays 0. Then sw at 32'h3002 and in_size=11 at 32'h3000 on consecutive cycles -> two consecutive pulses, misalign_addr ends at 32'h3000.
- Full/backpressure (DEPTH=2): out_ready=0, push 3 words back-to-back -> third stalls with in_ready=0, count=2, head output stable. Raise out_ready with in_valid held -> pop this edge, third accepted next edge, FIFO order A,B,C preserved.
- Simultaneous push/pop at count=1 -> count stays 1, data order correct. Pointer wrap verified over 10 consecutive entries with random out_ready.
